// File: rtl/act_pkg.sv
// Shared types, default widths and the saturation helper for the activation stage.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_GATED = 2'd3
  } act_mode_t;

  // Branch chosen in S1 and resolved in S2.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_X    = 2'd1,
    SEL_PROD = 2'd2
  } act_sel_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 8;

  // Clamp v to the signed range of a w-bit value (w <= 64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation datapath: S1 picks the branch and forms the raw
// product, S2 shifts, saturates and muxes the final result.
module act_lane
  import act_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s1_en,
  input  logic                    s2_en,
  input  logic                    lane_en,
  input  act_mode_t               mode,
  input  logic signed [WIDTH-1:0] leak,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] g,
  output logic        [WIDTH-1:0] y
);

  localparam int unsigned PW = 2 * WIDTH;

  logic                 x_pos;
  logic                 g_pos;
  act_sel_t             sel_c;
  logic signed [PW-1:0] prod_c;

  act_sel_t             sel_q;
  logic     [WIDTH-1:0] x_q;
  logic signed [PW-1:0] prod_q;

  logic signed [PW-1:0] shifted_c;
  logic     [WIDTH-1:0] sat_c;
  logic     [WIDTH-1:0] y_c;

  assign x_pos  = !x[WIDTH-1] && (x != '0);
  assign g_pos  = !g[WIDTH-1] && (g != '0);
  assign prod_c = PW'(x) * PW'(leak);

  always_comb begin
    sel_c = SEL_ZERO;
    if (lane_en) begin
      case (mode)
        ACT_PASS:  sel_c = SEL_X;
        ACT_RELU:  sel_c = x_pos ? SEL_X : SEL_ZERO;
        ACT_LEAKY: sel_c = x_pos ? SEL_X : SEL_PROD;
        ACT_GATED: sel_c = g_pos ? SEL_X : SEL_PROD;
        default:   sel_c = SEL_ZERO;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= SEL_ZERO;
      x_q    <= '0;
      prod_q <= '0;
    end else if (s1_en) begin
      sel_q  <= sel_c;
      x_q    <= x;
      prod_q <= prod_c;
    end
  end

  // Arithmetic shift truncates toward -inf before clamping.
  assign shifted_c = prod_q >>> FRAC;
  assign sat_c     = WIDTH'(saturate(64'(shifted_c), WIDTH));

  always_comb begin
    y_c = '0;
    case (sel_q)
      SEL_X:    y_c = x_q;
      SEL_PROD: y_c = sat_c;
      default:  y_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        y <= '0;
    else if (s2_en) y <= y_c;
  end

endmodule

// File: rtl/activation_unit.sv
// Multi-lane two-stage activation pipeline with valid/ready on both sides,
// per-beat captured configuration and an output beat counter.
module activation_unit
  import act_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_mode,
  input  logic [WIDTH-1:0]       cfg_leak,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES*WIDTH-1:0] in_gate,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_lane_en,
  output logic [15:0]            beat_count
);

  act_mode_t        mode_q;
  logic [WIDTH-1:0] leak_q;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;
  logic             s1_en;
  logic             s2_en;
  logic [LANES-1:0] s1_lane_en;

  // Config registers; a beat accepted on the cfg_we edge still sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= ACT_PASS;
      leak_q <= '0;
    end else if (cfg_we) begin
      mode_q <= act_mode_t'(cfg_mode);
      leak_q <= cfg_leak;
    end
  end

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign s1_en    = s1_load && in_valid;
  assign s2_en    = s2_load && s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_lane_en  <= '0;
      out_lane_en <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
      if (s1_en)   s1_lane_en <= in_lane_en;
      if (s2_en)   out_lane_en <= s1_lane_en;
    end
  end

  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst)                         beat_count <= '0;
    else if (s2_valid && out_ready)  beat_count <= beat_count + 16'd1;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .s1_en   (s1_en),
      .s2_en   (s2_en),
      .lane_en (in_lane_en[i]),
      .mode    (mode_q),
      .leak    (leak_q),
      .x       (in_data[i*WIDTH +: WIDTH]),
      .g       (in_gate[i*WIDTH +: WIDTH]),
      .y       (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed self-checking bench for activation_unit at the default Q8.8, 2-lane size.
module tb_activation_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_leak;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_gate;
  logic [1:0]  in_lane_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lane_en;
  logic [15:0] beat_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  activation_unit dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_mode    (cfg_mode),
    .cfg_leak    (cfg_leak),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_gate     (in_gate),
    .in_lane_en  (in_lane_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_lane_en (out_lane_en),
    .beat_count  (beat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [15:0] l);
    cfg_we = 1'b1; cfg_mode = m; cfg_leak = l;
    tick();
    cfg_we = 1'b0;
  endtask

  // Sends one beat with out_ready=1 and returns the delivered result.
  task automatic apply_beat(input logic [31:0] d, input logic [31:0] g, input logic [1:0] en,
                            output logic [31:0] obs, output logic [1:0] obs_en, output bit ok);
    out_ready = 1'b1;
    in_data = d; in_gate = g; in_lane_en = en; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    ok = out_valid;
    obs = out_data;
    obs_en = out_lane_en;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; cfg_mode = 2'd0; cfg_leak = 16'h0;
    in_valid = 1'b0; in_data = '0; in_gate = '0; in_lane_en = 2'b11; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    vectors++; if (out_lane_en !== 2'b00) begin errors++; $display("FAIL reset_lane_en got %b want 00", out_lane_en); end
    vectors++; if (beat_count !== 16'd0) begin errors++; $display("FAIL reset_beat_count got %0d want 0", beat_count); end
  endtask

  task automatic test_pass();
    in_data = {16'hFE00, 16'h0180}; in_gate = '0; in_lane_en = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_latency_early got %b want 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_latency got %b want 1", out_valid); end
    vectors++; if (out_data !== 32'hFE00_0180) begin errors++; $display("FAIL pass_data got %h want fe000180", out_data); end
    tick();
    vectors++; if (beat_count !== 16'd1) begin errors++; $display("FAIL pass_beat_count got %0d want 1", beat_count); end
  endtask

  task automatic test_leaky();
    logic [31:0] o; logic [1:0] e; bit ok;
    set_cfg(2'd2, 16'h0080);
    apply_beat({16'h0300, 16'hFE00}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0300_FF00) begin errors++; $display("FAIL leaky_half got %h want 0300ff00 (ok=%0d)", o, ok); end
    apply_beat({16'h0000, 16'hFFFF}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0000_FFFF) begin errors++; $display("FAIL leaky_trunc got %h want 0000ffff (ok=%0d)", o, ok); end
    set_cfg(2'd2, 16'h7FFF);
    apply_beat({16'h0100, 16'h8000}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0100_8000) begin errors++; $display("FAIL leaky_sat_neg got %h want 01008000 (ok=%0d)", o, ok); end
    set_cfg(2'd2, 16'h8000);
    apply_beat({16'h0000, 16'h8000}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0000_7FFF) begin errors++; $display("FAIL leaky_sat_pos got %h want 00007fff (ok=%0d)", o, ok); end
  endtask

  task automatic test_gated_relu();
    logic [31:0] o; logic [1:0] e; bit ok;
    set_cfg(2'd3, 16'h0040);
    apply_beat({16'h0200, 16'h0200}, {16'hFF00, 16'h0001}, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0080_0200) begin errors++; $display("FAIL gated got %h want 00800200 (ok=%0d)", o, ok); end
    apply_beat({16'h0200, 16'hFC00}, {16'h0000, 16'h0100}, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0080_FC00) begin errors++; $display("FAIL gated_zero_gate got %h want 0080fc00 (ok=%0d)", o, ok); end
    set_cfg(2'd1, 16'h0000);
    apply_beat({16'h0001, 16'hFE00}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'h0001_0000) begin errors++; $display("FAIL relu got %h want 00010000 (ok=%0d)", o, ok); end
    apply_beat({16'h0100, 16'h0100}, '0, 2'b01, o, e, ok);
    vectors++; if (!ok || o !== 32'h0000_0100) begin errors++; $display("FAIL lane_en_data got %h want 00000100 (ok=%0d)", o, ok); end
    vectors++; if (e !== 2'b01) begin errors++; $display("FAIL lane_en_out got %b want 01", e); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pat;
    int sent = 0, recv = 0, occ = 0;
    bit acc, xfer, stalled = 0;
    pat = 64'b1110_0011_0101_1000_0110_0010_1001_1100_0111_0100_1011_0001_1101_0010_0011_0100;
    rst = 1'b1; tick(); rst = 1'b0;
    set_cfg(2'd0, 16'h0000);
    in_gate = '0; in_lane_en = 2'b11;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      out_ready = (cyc < 64) ? pat[cyc] : 1'b1;
      in_valid = (sent < 8);
      in_data = {16'h2000 + 16'(sent), 16'h1000 + 16'(sent)};
      #1;
      vectors++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        errors++; $display("FAIL bp_in_ready cyc %0d got %b occ %0d out_ready %b", cyc, in_ready, occ, out_ready);
      end
      if (in_ready === 1'b0) stalled = 1;
      if (out_valid) begin
        vectors++;
        if (out_data !== {16'h2000 + 16'(recv), 16'h1000 + 16'(recv)}) begin
          errors++; $display("FAIL bp_data beat %0d got %h want %h", recv, out_data,
                             {16'h2000 + 16'(recv), 16'h1000 + 16'(recv)});
        end
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      @(posedge clk); #1;
      sent += int'(acc); recv += int'(xfer);
      occ = occ + int'(acc) - int'(xfer);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (recv != 8) begin errors++; $display("FAIL bp_count got %0d beats want 8", recv); end
    vectors++; if (!stalled) begin errors++; $display("FAIL bp_stall in_ready never dropped, want a drop"); end
    vectors++; if (beat_count !== 16'd8) begin errors++; $display("FAIL bp_beat_count got %0d want 8", beat_count); end
  endtask

  task automatic test_reconfig();
    logic [31:0] o; logic [1:0] e; bit ok;
    set_cfg(2'd2, 16'h0080);
    out_ready = 1'b0; in_data = {16'hFE00, 16'hFE00}; in_gate = '0; in_lane_en = 2'b11; in_valid = 1'b1;
    tick(); tick();
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rc_full in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    set_cfg(2'd1, 16'h0000);
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'hFF00_FF00) begin errors++; $display("FAIL rc_beat0 got %h v%b want ff00ff00", out_data, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'hFF00_FF00) begin errors++; $display("FAIL rc_beat1 got %h v%b want ff00ff00", out_data, out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0000) begin errors++; $display("FAIL rc_beat2 got %h v%b want 00000000", out_data, out_valid); end
    tick();
    // Beat accepted on the cfg_we edge keeps RELU; the next one sees LEAKY.
    cfg_we = 1'b1; cfg_mode = 2'd2; cfg_leak = 16'h0080; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000_0000) begin errors++; $display("FAIL rc_same_edge got %h v%b want 00000000", out_data, out_valid); end
    tick();
    apply_beat({16'hFE00, 16'hFE00}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'hFF00_FF00) begin errors++; $display("FAIL rc_after got %h want ff00ff00 (ok=%0d)", o, ok); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o; logic [1:0] e; bit ok;
    out_ready = 1'b0; in_data = {16'h1234, 16'h5678}; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    vectors++; if (beat_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", beat_count); end
    vectors++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h want 0", out_data); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush got %b want 0", out_valid); end
    apply_beat({16'hFE00, 16'h8001}, '0, 2'b11, o, e, ok);
    vectors++; if (!ok || o !== 32'hFE00_8001) begin errors++; $display("FAIL rst_mid_cfg got %h want fe008001 (ok=%0d)", o, ok); end
    vectors++; if (beat_count !== 16'd1) begin errors++; $display("FAIL rst_mid_count2 got %0d want 1", beat_count); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_leaky();
    test_gated_relu();
    test_backpressure();
    test_reconfig();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
# activation_unit

Parametrised, pipelined multi-lane activation stage for the vector path behind the systolic array. Each beat carries LANES signed fixed-point values. Each value is passed through, ReLU'd, leaky-ReLU'd, or gated by a companion operand; the gated mode applies the leaky-ReLU derivative during backprop. The block has valid/ready handshakes on both sides, full backpressure, per-beat captured configuration and a beat counter.

## Interface
- LANES, 2, number of parallel lanes
- WIDTH, 16, total bits per signed fixed-point value
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  load cfg_mode/cfg_leak into the config registers
- cfg_mode  in  2  activation mode (act_mode_t)
- cfg_leak  in  WIDTH  signed leak factor
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  LANES*WIDTH  lane values, lane 0 in the LSBs
- in_gate  in  LANES*WIDTH  gate operand per lane; used only in ACT_GATED
- in_lane_en  in  LANES  per-lane enable
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  LANES*WIDTH  results
- out_lane_en  out  LANES  in_lane_en carried with the beat
- beat_count  out  16  number of output beats transferred, wraps mod 2^16

## Operation
- Modes, per enabled lane, with x = data and g = gate:
  - ACT_PASS=0: out = x
  - ACT_RELU=1: out = x>0 ? x : 0
  - ACT_LEAKY=2: out = x>0 ? x : sat(x*leak)
  - ACT_GATED=3: out = g>0 ? x : sat(x*leak)
- Multiply: the full 2*WIDTH signed product is arithmetic-shifted right by FRAC (truncation toward -inf), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- The comparison ">0" is strict and signed. x=0 yields 0 in every mode.
- Disabled lanes output 0, regardless of mode.
- Config registers reset to mode ACT_PASS and leak 0.
- cfg_we takes effect for beats accepted in later cycles. A beat accepted in the same cycle as cfg_we uses the old config.
- Mode and leak are captured with each beat. Beats already in flight are unaffected by later cfg_we.
- beat_count increments on every cycle where out_valid && out_ready.

## Timing
- Two pipeline stages:
  - S1 registers the lane operands, the selected branch and the raw product.
  - S2 registers the shifted and saturated result. S2 drives out_* directly.
- Latency is 2 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
- Throughput is 1 beat per cycle while out_ready=1.
- S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
- in_ready = !(s1_valid && s2_valid && !out_ready). in_ready may depend combinationally on out_ready.
- While out_valid=1 && out_ready=0:
  - out_data and out_lane_en hold stable.
  - At most one more beat is accepted, filling S1. After that in_ready=0.
  - No beat is dropped or duplicated.
- Reset values: out_valid=0, in_ready=1 (from the cycle after reset), out_data=0, out_lane_en=0, beat_count=0, both stage valids 0. Reset asserted mid-stream discards all in-flight beats.
- Simultaneous acceptance into S1 and drain from S2 in the same cycle is the normal streaming case and must not bubble.

## Structure
- Package act_pkg:
  - act_mode_t enum, with ACT_PASS/RELU/LEAKY/GATED encoded 0-3
  - default WIDTH and FRAC localparams
  - a saturate function parametrised by WIDTH
- Sub-module act_lane: one lane's S1/S2 datapath, with a stall enable input. It is instantiated LANES times with a generate loop.
- activation_unit owns the shared valid/ready control, the config registers, the captured mode/leak pipeline and beat_count.

## Test plan
All values use the defaults (Q8.8, LANES=2).
- Reset, then ACT_PASS. Beat {0x0180, 0xFE00} -> out {0x0180, 0xFE00} two cycles later; beat_count=1.
- ACT_LEAKY, leak=0x0080 (0.5). {0xFE00, 0x0300} -> {0xFF00, 0x0300}. Also x=0xFFFF -> 0xFFFF (-1/256 × 0.5 truncates toward -inf).
- Saturation: ACT_LEAKY, leak=0x7FFF, x=0x8000 -> 0x8000.
- ACT_GATED, leak=0x0040. data {0x0200, 0x0200}, gate {0x0001, 0xFF00} -> {0x0200, 0x0080}. ACT_RELU on 0xFE00 -> 0x0000. Lane_en=2'b01 -> lane1 output 0.
- Backpressure:
  - Stream 8 beats with out_ready toggled randomly -> all 8 beats arrive in order, unchanged while stalled.
  - in_ready drops only when S1 and S2 are both full with out_ready=0.
  - beat_count=8.
- Mid-stream reconfiguration and reset:
  - cfg_we (LEAKY -> RELU) with 2 beats in flight -> those 2 beats use LEAKY, later beats use RELU.
  - rst with beats in flight -> out_valid=0 next cycle and beat_count=0.
